sd_adc_decimator: RTL
=====================

# sd_adc_decimator

Stereo first-order sigma-delta ADC front end with CIC decimation for the audio subsystem's line-in path. It closes the external loop: it samples two comparator pins and drives the matching 1-bit feedback pins into the external RC networks. It also decimates the resulting bitstreams into signed 16-bit PCM samples with a one-cycle valid strobe. It is the capture-side counterpart of the hybrid PWM/sigma-delta output DAC and shares its audio clock domain.

## Interface
- CLKDIV, 4: modulator tick period in clk cycles; legal range 1..255.
- DECIM_LOG2, 8: log2 of the decimation ratio R; legal range 8..12.
- clk  in  1  system/audio clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmp_l, cmp_r  in  1  external comparator outputs, asynchronous. High means the analog input is above the RC feedback voltage.
- fb_l, fb_r  out  1  registered feedback drive to the RC networks.
- q_l, q_r  out  16  signed two's-complement PCM samples.
- q_valid  out  1  one-clk pulse when q_l and q_r update.
- One clock; reset is asynchronous and active-low (clk, reset_n).

## Operation
- **Synchronizers:** each cmp input passes through a 2-flop synchronizer. Both flops reset to 0.
- **Prescaler:** counter runs 0..CLKDIV-1. A tick is the cycle in which the counter equals CLKDIV-1; the counter then wraps to 0. With CLKDIV=1, every cycle is a tick.
- **Modulator:** on each tick, fb_x <= synchronized cmp_x. The decimator input bit is the new fb_x value.
- **CIC, order 2:** per channel, with register width W = 2*DECIM_LOG2+1.
  - On each tick: int1 += bit, then int2 += int1 (int2 uses the updated int1).
  - All arithmetic is modulo 2^W and wraps freely.
- **Decimation counter:** DECIM_LOG2 bits, incremented on each tick. The tick on which it wraps from all-ones to 0 is a decimation tick.
- **Comb stage:** on a decimation tick, per channel:
  - c1 = int2 - d1; d1 <= int2.
  - y = c1 - d2; d2 <= c1.
  - All mod 2^W. y lies in 0..2^(2*DECIM_LOG2).
- **Output conversion:**
  - Clamp y = 2^(2*DECIM_LOG2) down to 2^(2*DECIM_LOG2)-1.
  - Take bits [2*DECIM_LOG2-1 : 2*DECIM_LOG2-16] and invert the MSB, converting offset binary to two's complement. This is a truncation, not rounding.
- **Settling:** a 2-bit settle counter counts decimation ticks, saturating at 2.
  - While it is below 2, the outputs are not loaded and q_valid stays low.
  - The first decimation tick that finds the counter at 2 is the first to update the outputs.
- **Channel symmetry:** both channels share the prescaler, decimation and settle counters. q_valid is common to both.

## Timing
- Reset values:
  - fb_l, fb_r = 0; q_l, q_r = 16'h0000; q_valid = 0.
  - All integrators, comb delays and counters = 0.
- Pin-to-feedback latency: a cmp edge reaches synchronizer stage 2 after 2 clk edges. It is captured by the first tick at or after that.
- On a decimation tick with settling complete:
  - q_l, q_r and q_valid=1 are registered at the clk edge that ends the tick cycle.
  - q_valid is high for exactly one cycle. q_l and q_r hold until the next update.
- Update period: exactly CLKDIV*2^DECIM_LOG2 clk cycles.
- First valid output: the 3rd decimation tick after reset release.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any q_valid in progress is dropped. Settling restarts after release.
- No back-pressure; the consumer must accept q on q_valid.

## Test plan
- **Full scale high:** cmp_l held 1, defaults (CLKDIV=4, DECIM_LOG2=8).
  - Expect no q_valid before the 3rd decimation tick.
  - Then q_l = 16'h7FFF (clamp path) on every pulse; fb_l stays 1.
- **Full scale low:** cmp_r held 0.
  - Expect q_r = 16'h8000 on every valid pulse; fb_r stays 0.
- **Midscale:** cmp_l toggled every tick (alternating 1/0 bitstream).
  - Expect q_l = 16'h0000 after settling.
- **Cadence:** defaults.
  - Expect q_valid pulses exactly 1024 clk cycles apart, each one cycle wide, with the first pulse after 3*1024 cycles.
  - Repeat with CLKDIV=1, DECIM_LOG2=12: period 4096 cycles.
- **Feedback latency:** with CLKDIV=1, raise cmp_l at a known edge.
  - Expect fb_l high 3 clk edges later.
- **Mid-operation reset:** pulse reset_n low for 1 cycle mid-stream with cmp_l=1.
  - Expect all outputs 0 immediately.
  - Expect the next q_valid exactly 3 decimation periods after release, with q_l = 16'h7FFF.

Source files
------------

// File: rtl/sd_adc_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_adc_decimator                                                |
// | Function : Stereo 1st-order sigma-delta ADC loop with CIC-2 decimation.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sd_adc_decimator #(
  parameter int CLKDIV     = 4,
  parameter int DECIM_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmp_l,
  input  logic        cmp_r,
  output logic        fb_l,
  output logic        fb_r,
  output logic [15:0] q_l,
  output logic [15:0] q_r,
  output logic        q_valid
);

  localparam int         c_W        = 2 * DECIM_LOG2 + 1;
  localparam int         c_Y        = 2 * DECIM_LOG2;
  localparam logic [7:0] c_PRE_LAST = 8'(CLKDIV - 1);

  logic [7:0]            r_pre;
  logic [DECIM_LOG2-1:0] r_dcnt;
  logic [1:0]            r_settle;
  logic                  r_valid;
  logic                  w_tick;
  logic                  w_dtick;
  logic                  w_load;
  logic [1:0]            w_cmp;

  assign w_tick  = (r_pre == c_PRE_LAST);
  assign w_dtick = w_tick & (&r_dcnt);
  assign w_load  = w_dtick & (r_settle == 2'd2);
  assign w_cmp   = {cmp_r, cmp_l};

  // Shared timing: prescaler, decimation counter and settle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre    <= 8'd0;
      r_dcnt   <= '0;
      r_settle <= 2'd0;
      r_valid  <= 1'b0;
    end else begin
      r_pre   <= w_tick ? 8'd0 : r_pre + 8'd1;
      r_valid <= w_load;
      if (w_tick) begin
        r_dcnt <= r_dcnt + 1'b1;
      end
      if (w_dtick && (r_settle != 2'd2)) begin
        r_settle <= r_settle + 2'd1;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [1:0]     r_sync;
    logic           r_fb;
    logic [c_W-1:0] r_int1;
    logic [c_W-1:0] r_int2;
    logic [c_W-1:0] r_d1;
    logic [c_W-1:0] r_d2;
    logic [15:0]    r_q;
    logic           w_bit;
    logic [c_W-1:0] w_int1_nxt;
    logic [c_W-1:0] w_int2_nxt;
    logic [c_W-1:0] w_c1;
    logic [c_W-1:0] w_y;
    logic [15:0]    w_pcm;

    assign w_bit      = r_sync[1];
    assign w_int1_nxt = r_int1 + {{(c_W-1){1'b0}}, w_bit};
    assign w_int2_nxt = r_int2 + w_int1_nxt;
    assign w_c1       = w_int2_nxt - r_d1;
    assign w_y        = w_c1 - r_d2;
    // Only y == 2^c_Y sets the top bit; it saturates to positive full scale
    assign w_pcm      = w_y[c_Y] ? 16'h7FFF : {~w_y[c_Y-1], w_y[c_Y-2 -: 15]};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= 2'b00;
        r_fb   <= 1'b0;
        r_int1 <= '0;
        r_int2 <= '0;
        r_d1   <= '0;
        r_d2   <= '0;
        r_q    <= 16'h0000;
      end else begin
        r_sync <= {r_sync[0], w_cmp[i]};
        if (w_tick) begin
          r_fb   <= w_bit;
          r_int1 <= w_int1_nxt;
          r_int2 <= w_int2_nxt;
        end
        if (w_dtick) begin
          r_d1 <= w_int2_nxt;
          r_d2 <= w_c1;
        end
        if (w_load) begin
          r_q <= w_pcm;
        end
      end
    end
  end

  assign fb_l    = g_ch[0].r_fb;
  assign fb_r    = g_ch[1].r_fb;
  assign q_l     = g_ch[0].r_q;
  assign q_r     = g_ch[1].r_q;
  assign q_valid = r_valid;

endmodule
`default_nettype wire
